// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Accepts bytes over valid/ready, issues tx_start pulses, and bounds each grant to MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 8,
  parameter int START_TIMEOUT = 16,
  localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic                 tx_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  localparam logic [7:0]    BURST_CAP    = 8'(MAX_BURST);
  // tx_err lands exactly START_TIMEOUT cycles after the tx_start cycle.
  localparam logic [7:0]    TIMEOUT_LAST = 8'(START_TIMEOUT - 2);
  localparam logic [GW-1:0] LAST_REQ     = GW'(NUM_REQ - 1);

  state_t        state, state_d;
  logic [GW-1:0] grant_id_d, last_grant, last_grant_d, winner, cand;
  logic          grant_valid_d, last_flag, last_flag_d, tx_start_d, tx_err_d, found;
  logic [7:0]    burst_cnt, burst_cnt_d, timeout_cnt, timeout_cnt_d, tx_data_d;

  // Rotating scan starting just after the previous owner.
  always_comb begin
    winner = last_grant;
    cand   = last_grant;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_REQ) ? '0 : cand + GW'(1);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state;
    grant_id_d    = grant_id;
    grant_valid_d = grant_valid;
    last_grant_d  = last_grant;
    burst_cnt_d   = burst_cnt;
    last_flag_d   = last_flag;
    timeout_cnt_d = timeout_cnt;
    tx_data_d     = tx_data;
    tx_start_d    = 1'b0;
    tx_err_d      = 1'b0;

    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          grant_id_d    = winner;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        if (req_valid[grant_id]) begin
          tx_data_d   = req_data[{grant_id, 3'b000} +: 8];
          last_flag_d = req_last[grant_id];
          burst_cnt_d = burst_cnt + 8'd1;
          tx_start_d  = 1'b1;
          state_d     = S_START;
        end else begin
          last_grant_d  = grant_id;
          grant_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      S_START: begin
        timeout_cnt_d = '0;
        state_d       = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          // The byte is dropped; the grant moves on rather than retrying.
          tx_err_d      = 1'b1;
          last_grant_d  = grant_id;
          grant_valid_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (!last_flag && (burst_cnt < BURST_CAP)) begin
            state_d = S_GRANT;
          end else begin
            last_grant_d  = grant_id;
            grant_valid_d = 1'b0;
            state_d       = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every state bit has a reset value, so a mid-frame reset leaves nothing stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      last_grant  <= LAST_REQ;
      burst_cnt   <= '0;
      last_flag   <= 1'b0;
      timeout_cnt <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state       <= state_d;
      grant_id    <= grant_id_d;
      grant_valid <= grant_valid_d;
      last_grant  <= last_grant_d;
      burst_cnt   <= burst_cnt_d;
      last_flag   <= last_flag_d;
      timeout_cnt <= timeout_cnt_d;
      tx_data     <= tx_data_d;
      tx_start    <= tx_start_d;
      tx_err      <= tx_err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_GRANT) req_ready[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a simple transmitter model
// and a frame log compared against hand-computed sequences.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int FRAME_LEN = 6;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 grant_valid;
  logic [1:0]           grant_id;
  logic                 tx_err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(8), .START_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .tx_err     (tx_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cyc;
  } frame_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_left = 0;
  bit          model_en = 1'b1;
  logic [8:0]  src_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] pend;
  frame_t      frames [$];
  int          err_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Producers: present the head of each queue, pop it once a handshake has completed.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    pend      = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++)
        if (pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]       = src_q[i][0][8];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
      pend = req_valid & req_ready & {NUM_REQ{reset}};
    end
  end

  // Transmitter model: busy for FRAME_LEN cycles after each start, cleared by the shared reset.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        tx_busy   = 1'b0;
        busy_left = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end else if (model_en && tx_start) begin
        tx_busy   = 1'b1;
        busy_left = FRAME_LEN;
      end
    end
  end

  initial forever begin
    frame_t f;
    @(negedge clk);
    #1;
    if (tx_start) begin
      f.id   = int'(grant_id);
      f.data = tx_data;
      f.cyc  = cyc;
      frames.push_back(f);
    end
    if (tx_err) err_cyc.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    frames.delete();
    err_cyc.delete();
  endtask

  task automatic wait_idle(input string tag, input int n_frames, input int budget);
    int k = 0;
    while (k < budget && !(frames.size() >= n_frames && !grant_valid && queues_empty())) begin
      tick();
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input int id, input int budget);
    int k = 0;
    while (k < budget && !(grant_valid && int'(grant_id) == id)) begin
      tick();
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int k, input int id, input logic [7:0] d);
    if (k < frames.size()) begin
      check({tag, "_id"}, 32'(frames[k].id), 32'(id));
      check({tag, "_data"}, 32'(frames[k].data), 32'(d));
    end else begin
      check({tag, "_missing"}, 32'(frames.size()), 32'(k + 1));
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    clear_logs();
  endtask

  initial begin
    int k;
    logic [7:0] exp_b;

    // Reset state
    #1 reset = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_grant_valid", 32'(grant_valid), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_tx_err", 32'(tx_err), 32'h0);
    reset = 1'b1;
    tick();
    clear_logs();

    // Single byte from requester 2, cycle by cycle
    src_q[2].push_back({1'b1, 8'hA5});
    tick();
    check("t1_idle_ready", 32'(req_ready), 32'h0);
    check("t1_idle_gv", 32'(grant_valid), 32'h0);
    tick();
    check("t1_grant_gv", 32'(grant_valid), 32'h1);
    check("t1_grant_id", 32'(grant_id), 32'h2);
    check("t1_grant_ready", 32'(req_ready), 32'b0100);
    check("t1_grant_start", 32'(tx_start), 32'h0);
    tick();
    check("t1_start_pulse", 32'(tx_start), 32'h1);
    check("t1_start_data", 32'(tx_data), 32'hA5);
    check("t1_start_ready", 32'(req_ready), 32'h0);
    tick();
    check("t1_start_end", 32'(tx_start), 32'h0);
    k = 0;
    while (tx_busy && k < 50) begin
      tick();
      k++;
    end
    check("t1_busy_fell", 32'(tx_busy), 32'h0);
    check("t1_gv_hold", 32'(grant_valid), 32'h1);
    tick();
    check("t1_gv_fall", 32'(grant_valid), 32'h0);
    check("t1_data_stable", 32'(tx_data), 32'hA5);
    check("t1_frames", 32'(frames.size()), 32'd1);

    // Round-robin with all four requesting
    apply_reset();
    src_q[0].push_back({1'b1, 8'h10});
    src_q[1].push_back({1'b1, 8'h11});
    src_q[2].push_back({1'b1, 8'h12});
    src_q[3].push_back({1'b1, 8'h13});
    src_q[0].push_back({1'b1, 8'h14});
    src_q[1].push_back({1'b1, 8'h15});
    wait_idle("t2_done", 6, 400);
    check_frame("t2_f0", 0, 0, 8'h10);
    check_frame("t2_f1", 1, 1, 8'h11);
    check_frame("t2_f2", 2, 2, 8'h12);
    check_frame("t2_f3", 3, 3, 8'h13);
    check_frame("t2_f4", 4, 0, 8'h14);
    check_frame("t2_f5", 5, 1, 8'h15);

    // Burst of three from requester 1 while requester 0 waits
    clear_logs();
    src_q[1].push_back({1'b0, 8'h01});
    src_q[1].push_back({1'b0, 8'h02});
    src_q[1].push_back({1'b1, 8'h03});
    wait_grant("t3_grant1", 1, 50);
    src_q[0].push_back({1'b1, 8'h0A});
    wait_idle("t3_done", 4, 400);
    check_frame("t3_f0", 0, 1, 8'h01);
    check_frame("t3_f1", 1, 1, 8'h02);
    check_frame("t3_f2", 2, 1, 8'h03);
    check_frame("t3_f3", 3, 0, 8'h0A);

    // Burst cap: ten unterminated bytes from requester 3
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      exp_b = 8'h30 + 8'(i);
      src_q[3].push_back({1'b0, exp_b});
    end
    wait_grant("t4_grant3", 3, 50);
    src_q[0].push_back({1'b1, 8'h0B});
    wait_idle("t4_done", 11, 800);
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'h30 + 8'(i);
      check_frame("t4_burst", i, 3, exp_b);
    end
    check_frame("t4_rot", 8, 0, 8'h0B);
    check_frame("t4_res0", 9, 3, 8'h38);
    check_frame("t4_res1", 10, 3, 8'h39);

    // Start timeout with the transmitter never going busy
    clear_logs();
    model_en = 1'b0;
    src_q[2].push_back({1'b1, 8'hC2});
    src_q[3].push_back({1'b1, 8'hC3});
    wait_idle("t5_done", 2, 200);
    check_frame("t5_f0", 0, 2, 8'hC2);
    check_frame("t5_f1", 1, 3, 8'hC3);
    check("t5_err_count", 32'(err_cyc.size()), 32'd2);
    if (err_cyc.size() >= 2 && frames.size() >= 2) begin
      check("t5_err0_delay", 32'(err_cyc[0] - frames[0].cyc), 32'd16);
      check("t5_err1_delay", 32'(err_cyc[1] - frames[1].cyc), 32'd16);
    end
    model_en = 1'b1;

    // Reset during WAIT_DONE
    clear_logs();
    src_q[1].push_back({1'b1, 8'hD1});
    k = 0;
    while (!tx_busy && k < 30) begin
      tick();
      k++;
    end
    check("t6_busy_seen", 32'(tx_busy), 32'h1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("t6_rst_gv", 32'(grant_valid), 32'h0);
    check("t6_rst_id", 32'(grant_id), 32'h0);
    check("t6_rst_data", 32'(tx_data), 32'h00);
    check("t6_rst_start", 32'(tx_start), 32'h0);
    check("t6_rst_err", 32'(tx_err), 32'h0);
    check("t6_rst_ready", 32'(req_ready), 32'h0);
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    clear_logs();
    src_q[3].push_back({1'b1, 8'hE3});
    src_q[0].push_back({1'b1, 8'hE0});
    wait_idle("t6_done", 2, 200);
    check_frame("t6_f0", 0, 0, 8'hE0);
    check_frame("t6_f1", 1, 3, 8'hE3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes.
- Drives the transmitter's parallel-load interface (data + start pulse).
- Tracks transmitter busy to sequence frames; supports short locked bursts per grant.
- Sits between on-chip producers (command responder, debug logger, etc.) and the transmitter/baud generator pair.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 8: maximum bytes sent per grant before forced rotation, 1..255.
- START_TIMEOUT, 16: cycles allowed for tx_busy to rise after tx_start before abort, 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NUM_REQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*NUM_REQ  packed request bytes, requester 0 in bits [7:0].
- req_last  in  NUM_REQ  byte offered by requester i ends its burst.
- req_ready  out  NUM_REQ  one-hot; byte accepted on a cycle where req_valid[i] && req_ready[i].
- tx_data  out  8  byte presented to transmitter.
- tx_start  out  1  one-cycle pulse requesting transmitter to begin a frame.
- tx_busy  in  1  transmitter frame in progress (start through stop bit).
- grant_valid  out  1  a requester currently owns the transmitter.
- grant_id  out  clog2(NUM_REQ) (min 1)  index of owning requester; valid when grant_valid.
- tx_err  out  1  one-cycle pulse: transmitter failed to go busy within START_TIMEOUT.

Behaviour:
- Reset (reset=0, async): state=IDLE, req_ready=0, tx_data=8'h00, tx_start=0, grant_valid=0, grant_id=0, tx_err=0, burst_cnt=0, timeout_cnt=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
- Deassertion of reset is synchronous to clk: first active edge follows the first clk rising edge after reset goes high.
- States: IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE. All outputs are registered except req_ready, which is decoded (state==GRANT) one-hot at grant_id.
- IDLE, any req_valid set:
  - Winner = first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Next edge: grant_id=winner, grant_valid=1, burst_cnt=0, state=GRANT.
  - With no req_valid set, remain in IDLE.
- GRANT: req_ready[grant_id]=1.
  - If req_valid[grant_id]: capture req_data slice into tx_data, capture req_last into last_flag, increment burst_cnt, go to START.
  - If req_valid[grant_id]=0 (requester withdrew): last_grant=grant_id, grant_valid=0, go to IDLE.
- START: tx_start=1 for exactly this one cycle; timeout_cnt=0; go to WAIT_BUSY.
- WAIT_BUSY: tx_start=0.
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment timeout_cnt; on reaching START_TIMEOUT: tx_err pulses one cycle, last_grant=grant_id, grant_valid=0, go to IDLE. The byte is dropped, not retried.
- WAIT_DONE, on tx_busy=0:
  - If last_flag=0 and burst_cnt<MAX_BURST: go to GRANT with the same grant_id (burst continues).
  - Otherwise: last_grant=grant_id, grant_valid=0, go to IDLE.
- tx_data holds stable from START until the next GRANT capture. tx_data is never changed while tx_busy=1.
- Latency: valid in IDLE at cycle n → req_ready high cycle n+1 (byte accepted) → tx_start high cycle n+2. Minimum inter-frame gap after tx_busy falls: 2 cycles (WAIT_DONE→GRANT→START).
- Fairness: a requester with valid held is granted within NUM_REQ-1 other grants. MAX_BURST bounds each grant.
- Simultaneous requests resolve purely by rotation pointer; no fixed priority after reset.
- req_valid changes in states other than IDLE/GRANT are ignored. Non-granted requesters never see req_ready.
- tx_busy already high on entering WAIT_BUSY is legal: move to WAIT_DONE next edge.
- Reset mid-frame: returns immediately to reset values. The transmitter shares the reset, so the in-flight byte is lost and no tx_start is issued.

Test Plan:
- Single byte: reset then release; req_valid=4'b0100, data 8'hA5, req_last=1 → grant_id=2, req_ready[2] one cycle, tx_data=8'hA5, tx_start one cycle, grant_valid falls 1 cycle after tx_busy falls.
- Round-robin: all four valid continuously, req_last=1, distinct bytes 8'h10..8'h13 → frames issued in order 0,1,2,3,0,1; no requester granted twice in a row.
- Burst: requester 1 sends 3 bytes 8'h01,02,03 with req_last only on third while requester 0 valid → all 3 sent under grant_id=1 before grant_id=0.
- Burst cap: MAX_BURST=8, requester 3 sends 10 bytes with req_last=0, requester 0 also valid → 8 bytes then rotation to 0, then 3 resumes for remaining 2.
- Timeout: tx_busy tied 0 → tx_err pulses exactly 16 cycles after the tx_start cycle, grant released, next requester granted.
- Reset mid-operation: assert reset during WAIT_DONE → all outputs at reset values asynchronously. After release, requester 0 is granted first.
